// File: rtl/npu_loop_ctrl.sv
// npu_loop_ctrl: loop-nest counter bank for the NPU tile engine.
// On an accepted start it captures the eight loop limits. It then steps the
// counters from the sequencer strobes and reports terminal-count flags and
// loop indices.
// Counter slots: 0 npu, 1 hmode, 2 vmode, 3 ifmaps, 4 res, 5 tileh, 6 tilev, 7 ofmaps.
// Optional feature macro: NPU_LOOP_PERF_EN adds a saturating 32-bit busy-cycle counter.
module npu_loop_ctrl #(
    parameter int CW = 8
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] cfg_lim_npu,
    input  logic [CW-1:0] cfg_lim_hmode,
    input  logic [CW-1:0] cfg_lim_vmode,
    input  logic [CW-1:0] cfg_lim_ifmaps,
    input  logic [CW-1:0] cfg_lim_res,
    input  logic [CW-1:0] cfg_lim_tileh,
    input  logic [CW-1:0] cfg_lim_tilev,
    input  logic [CW-1:0] cfg_lim_ofmaps,
    input  logic          ctrl_en_npu,
    input  logic          ctrl_en_hmode,
    input  logic          ctrl_en_vmode,
    input  logic          ctrl_wr_mem,
    input  logic          done,
    output logic          s_tc_npu_ptr,
    output logic          s_tc_hmode,
    output logic          s_tc_vmode,
    output logic          s_tc_ifmaps,
    output logic          s_tc_res,
    output logic          s_tc_tileh,
    output logic          s_tc_tilev,
    output logic          s_tc_ofmaps,
    output logic [CW-1:0] idx_npu,
    output logic [CW-1:0] idx_ifmaps,
    output logic [CW-1:0] idx_res,
    output logic [CW-1:0] idx_tileh,
    output logic [CW-1:0] idx_tilev,
    output logic [CW-1:0] idx_ofmaps,
    output logic          busy,
    output logic          wrap_err
`ifdef NPU_LOOP_PERF_EN
    ,
    output logic [31:0]   perf_cycles
`endif
);

    localparam int NC = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] lim_reg [NC];
    logic [CW-1:0] cnt_reg [NC];
    logic [CW-1:0] cfg_lim [NC];
    logic [NC-1:0] at_lim;
    logic [NC-1:0] step;
    logic          wrap_carry;
    logic          run;
    logic          accept;

    assign cfg_lim[0] = cfg_lim_npu;
    assign cfg_lim[1] = cfg_lim_hmode;
    assign cfg_lim[2] = cfg_lim_vmode;
    assign cfg_lim[3] = cfg_lim_ifmaps;
    assign cfg_lim[4] = cfg_lim_res;
    assign cfg_lim[5] = cfg_lim_tileh;
    assign cfg_lim[6] = cfg_lim_tilev;
    assign cfg_lim[7] = cfg_lim_ofmaps;

    assign run    = (state_reg == RUN);
    assign accept = (state_reg == IDLE) && start;

    // Per-counter terminal compare; these come from registers only.
    for (genvar gi = 0; gi < NC; gi++) begin : g_at_lim
        assign at_lim[gi] = (cnt_reg[gi] == lim_reg[gi]);
    end

    // Step enables. Each chained counter's enable is written as the full
    // product of its upstream terms so that the ripple settles in one cycle
    // without a self-referencing vector.
    assign step[0]    = ctrl_en_npu;
    assign step[1]    = ctrl_en_hmode;
    assign step[2]    = ctrl_en_vmode;
    assign step[3]    = ctrl_en_npu & at_lim[0];
    assign step[4]    = ctrl_wr_mem;
    assign step[5]    = ctrl_wr_mem & at_lim[4];
    assign step[6]    = ctrl_wr_mem & at_lim[4] & at_lim[5];
    assign step[7]    = ctrl_wr_mem & at_lim[4] & at_lim[5] & at_lim[6];
    assign wrap_carry = step[7] & at_lim[7];

    // State register.
    always_ff @(posedge ck) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next state: start opens a job; done closes it after this cycle's strobes.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        case (state_reg)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Limit capture, counter stepping and sticky wrap flag.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            for (int i = 0; i < NC; i++) begin
                lim_reg[i] <= '0;
                cnt_reg[i] <= '0;
            end
            wrap_err <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < NC; i++) begin
                lim_reg[i] <= cfg_lim[i];
                cnt_reg[i] <= '0;
            end
            wrap_err <= 1'b0;
        end else if (run) begin
            for (int i = 0; i < NC; i++) begin
                if (step[i]) cnt_reg[i] <= at_lim[i] ? '0 : cnt_reg[i] + CW'(1);
            end
            if (wrap_carry) wrap_err <= 1'b1;
        end
    end

`ifdef NPU_LOOP_PERF_EN
    logic [31:0] perf_reg;

    // Busy-cycle counter: restarts on a new job, saturates, holds in IDLE.
    always_ff @(posedge ck) begin
        if (!rst_n)                            perf_reg <= '0;
        else if (accept)                       perf_reg <= '0;
        else if (run && perf_reg != '1)        perf_reg <= perf_reg + 32'd1;
    end

    assign perf_cycles = perf_reg;
`endif

    assign s_tc_npu_ptr = run & at_lim[0];
    assign s_tc_hmode   = run & at_lim[1];
    assign s_tc_vmode   = run & at_lim[2];
    assign s_tc_ifmaps  = run & at_lim[3];
    assign s_tc_res     = run & at_lim[4];
    assign s_tc_tileh   = run & at_lim[5];
    assign s_tc_tilev   = run & at_lim[6];
    assign s_tc_ofmaps  = run & at_lim[7];

    assign idx_npu    = cnt_reg[0];
    assign idx_ifmaps = cnt_reg[3];
    assign idx_res    = cnt_reg[4];
    assign idx_tileh  = cnt_reg[5];
    assign idx_tilev  = cnt_reg[6];
    assign idx_ofmaps = cnt_reg[7];

endmodule

// File: tb/tb_npu_loop_ctrl.sv
// Testbench for npu_loop_ctrl: directed scenarios plus random strobes.
// A loop-nest reference model predicts the outputs after each edge and
// queues the prediction. A negedge monitor pops each queued prediction and
// compares it against the design outputs.
// Define NPU_LOOP_PERF_EN to check perf_cycles as well.
module tb_npu_loop_ctrl;

    localparam int CW = 8;

    logic          ck = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cfg [8];
    logic          en_npu = 1'b0, en_h = 1'b0, en_v = 1'b0, wr = 1'b0, dn = 1'b0;
    logic          s_tc_npu_ptr, s_tc_hmode, s_tc_vmode, s_tc_ifmaps;
    logic          s_tc_res, s_tc_tileh, s_tc_tilev, s_tc_ofmaps;
    logic [CW-1:0] idx_npu, idx_ifmaps, idx_res, idx_tileh, idx_tilev, idx_ofmaps;
    logic          busy, wrap_err;
`ifdef NPU_LOOP_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    always #5 ck = ~ck;

    npu_loop_ctrl #(.CW(CW)) dut (
        .ck(ck), .rst_n(rst_n), .start(start),
        .cfg_lim_npu(cfg[0]), .cfg_lim_hmode(cfg[1]), .cfg_lim_vmode(cfg[2]),
        .cfg_lim_ifmaps(cfg[3]), .cfg_lim_res(cfg[4]), .cfg_lim_tileh(cfg[5]),
        .cfg_lim_tilev(cfg[6]), .cfg_lim_ofmaps(cfg[7]),
        .ctrl_en_npu(en_npu), .ctrl_en_hmode(en_h), .ctrl_en_vmode(en_v),
        .ctrl_wr_mem(wr), .done(dn),
        .s_tc_npu_ptr(s_tc_npu_ptr), .s_tc_hmode(s_tc_hmode), .s_tc_vmode(s_tc_vmode),
        .s_tc_ifmaps(s_tc_ifmaps), .s_tc_res(s_tc_res), .s_tc_tileh(s_tc_tileh),
        .s_tc_tilev(s_tc_tilev), .s_tc_ofmaps(s_tc_ofmaps),
        .idx_npu(idx_npu), .idx_ifmaps(idx_ifmaps), .idx_res(idx_res),
        .idx_tileh(idx_tileh), .idx_tilev(idx_tilev), .idx_ofmaps(idx_ofmaps),
        .busy(busy), .wrap_err(wrap_err)
`ifdef NPU_LOOP_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    typedef struct {
        int          idx [6];
        logic [7:0]  tc;
        logic        busy;
        logic        wrap;
        logic [31:0] perf;
    } exp_t;

    exp_t sb [$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_txn = 0;

    // Reference model: loop nest with inclusive limits.
    int          mcnt [8];
    int          mlim [8];
    bit          mbusy = 0;
    bit          mwrap = 0;
    logic [31:0] mperf = '0;

    // Advance one loop; returns 1 when it wraps back to zero.
    function automatic bit adv(int i);
        if (mcnt[i] == mlim[i]) begin
            mcnt[i] = 0;
            return 1'b1;
        end
        mcnt[i] = mcnt[i] + 1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin mcnt[i] = 0; mlim[i] = 0; end
            mbusy = 0; mwrap = 0; mperf = '0;
        end else if (!mbusy) begin
            if (start) begin
                for (int i = 0; i < 8; i++) begin mlim[i] = int'(cfg[i]); mcnt[i] = 0; end
                mwrap = 0; mbusy = 1; mperf = '0;
            end
        end else begin
            if (mperf != 32'hFFFF_FFFF) mperf = mperf + 32'd1;
            if (en_npu) begin
                if (adv(0)) void'(adv(3));
            end
            if (en_h) void'(adv(1));
            if (en_v) void'(adv(2));
            if (wr) begin
                if (adv(4)) begin
                    if (adv(5)) begin
                        if (adv(6)) begin
                            if (adv(7)) mwrap = 1;
                        end
                    end
                end
            end
            if (dn) mbusy = 0;
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        e.idx[0] = mcnt[0]; e.idx[1] = mcnt[3]; e.idx[2] = mcnt[4];
        e.idx[3] = mcnt[5]; e.idx[4] = mcnt[6]; e.idx[5] = mcnt[7];
        for (int i = 0; i < 8; i++) e.tc[i] = mbusy && (mcnt[i] == mlim[i]);
        e.busy = mbusy;
        e.wrap = mwrap;
        e.perf = mperf;
        return e;
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // One clock: inputs are already driven; apply the edge, queue the prediction.
    task automatic cyc(input bit r, input bit s, input bit a, input bit h,
                       input bit v, input bit w, input bit d);
        rst_n = r; start = s; en_npu = a; en_h = h; en_v = v; wr = w; dn = d;
        @(posedge ck);
        model_edge();
        sb.push_back(predict());
        @(negedge ck);
    endtask

    // Monitor: every cycle is an output beat; compare against the oldest prediction.
    always @(negedge ck) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_txn++;
            chk("busy", busy, e.busy);
            chk("wrap_err", wrap_err, e.wrap);
            chk("idx_npu", idx_npu, e.idx[0]);
            chk("idx_ifmaps", idx_ifmaps, e.idx[1]);
            chk("idx_res", idx_res, e.idx[2]);
            chk("idx_tileh", idx_tileh, e.idx[3]);
            chk("idx_tilev", idx_tilev, e.idx[4]);
            chk("idx_ofmaps", idx_ofmaps, e.idx[5]);
            chk("s_tc_flags", {s_tc_ofmaps, s_tc_tilev, s_tc_tileh, s_tc_res,
                               s_tc_ifmaps, s_tc_vmode, s_tc_hmode, s_tc_npu_ptr}, e.tc);
`ifdef NPU_LOOP_PERF_EN
            chk("perf_cycles", perf_cycles, e.perf);
`endif
            $display("txn %0d busy=%0b wrap=%0b npu=%0d ifm=%0d res=%0d th=%0d tv=%0d ofm=%0d tc=%b",
                     n_txn, busy, wrap_err, idx_npu, idx_ifmaps, idx_res, idx_tileh,
                     idx_tilev, idx_ofmaps,
                     {s_tc_ofmaps, s_tc_tilev, s_tc_tileh, s_tc_res,
                      s_tc_ifmaps, s_tc_vmode, s_tc_hmode, s_tc_npu_ptr});
        end
    end

    initial begin
        int exp_npu [6] = '{1, 2, 0, 1, 2, 0};
        int exp_ifm [6] = '{0, 0, 1, 1, 1, 0};
        int exp_tcn [6] = '{0, 1, 0, 0, 1, 0};

        for (int i = 0; i < 8; i++) cfg[i] = 8'd5;
        @(negedge ck);

        // Reset, then every strobe while idle.
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 1, 1);
        cyc(1, 0, 1, 1, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);

        // Basic wrap: npu limit 2, ifmaps limit 1.
        cfg[0] = 8'd2; cfg[3] = 8'd1;
        cyc(1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            cyc(1, 0, 1, 0, 0, 0, 0);
            chk("wrap_seq_idx_npu", idx_npu, exp_npu[k]);
            chk("wrap_seq_idx_ifmaps", idx_ifmaps, exp_ifm[k]);
            chk("wrap_seq_tc_npu", s_tc_npu_ptr, exp_tcn[k]);
        end
        cyc(1, 0, 0, 0, 0, 0, 1);

        // Full ripple through the res chain.
        for (int i = 4; i < 8; i++) cfg[i] = 8'd1;
        cyc(1, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            cyc(1, 0, 0, 0, 0, 1, 0);
            if (k == 15)
                chk("ripple_tc_all_at_15", {s_tc_res, s_tc_tileh, s_tc_tilev, s_tc_ofmaps}, 4'b1111);
            if (k == 16) begin
                chk("ripple_wrap_at_16", wrap_err, 1);
                chk("ripple_zero_at_16", {idx_res, idx_tileh, idx_tilev, idx_ofmaps}, 0);
            end
        end

        // Simultaneous steps and done, then a fresh start clears state.
        cyc(1, 0, 1, 0, 0, 1, 1);
        chk("simul_busy_low", busy, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);

        // Start while busy with a zero limit on vmode.
        cyc(1, 0, 0, 0, 0, 0, 1);
        cfg[2] = 8'd0; cfg[0] = 8'd3;
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 1, 0, 0);
        cfg[0] = 8'd0; cfg[2] = 8'd7;
        cyc(1, 1, 0, 0, 1, 0, 0);
        cyc(1, 0, 1, 1, 1, 1, 0);

        // Reset in the middle of a run, then a counted job.
        cyc(0, 0, 1, 1, 1, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(1, 0, 1, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0);

        // Random phase with small limits so wraps are frequent.
        for (int k = 0; k < 1500; k++) begin
            bit r, s, d;
            r = ($urandom_range(0, 99) != 0);
            s = ($urandom_range(0, 9) == 0);
            d = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < 8; i++) cfg[i] = CW'($urandom_range(0, 3));
            cyc(r, s, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), d);
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge ck);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/npu_loop_ctrl.md
# npu_loop_ctrl

Loop-nest counter bank for the NPU tile engine. It sits between the NPU sequencing FSM and the configuration registers. On `start` it captures per-loop limits, then advances a set of chained and independent counters from the FSM's enable strobes. It returns the terminal-count flags `s_tc_*` that drive the FSM's state transitions, plus the current loop indices used for addressing.

## Interface
- `CW`, default 8: width of every loop counter and limit.
- `ck` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `start` input 1: job start pulse; accepted only when `busy`=0.
- `cfg_lim_npu`, `cfg_lim_hmode`, `cfg_lim_vmode`, `cfg_lim_ifmaps`, `cfg_lim_res`, `cfg_lim_tileh`, `cfg_lim_tilev`, `cfg_lim_ofmaps` input CW each: last index (inclusive) of each loop.
- `ctrl_en_npu`, `ctrl_en_hmode`, `ctrl_en_vmode`, `ctrl_wr_mem`, `done` input 1 each: step strobes and job-end strobe from the FSM.
- `s_tc_npu_ptr`, `s_tc_hmode`, `s_tc_vmode`, `s_tc_ifmaps`, `s_tc_res`, `s_tc_tileh`, `s_tc_tilev`, `s_tc_ofmaps` output 1 each: terminal-count flags.
- `idx_npu`, `idx_ifmaps`, `idx_res`, `idx_tileh`, `idx_tilev`, `idx_ofmaps` output CW each: current counter values.
- `busy` output 1: job in progress.
- `wrap_err` output 1: sticky flag; the outermost loop wrapped past its limit.

## Operation
- States: IDLE (`busy`=0) and RUN (`busy`=1).
- Reset (`rst_n`=0 at an edge): all counters 0, all limit registers 0, `busy`=0, `wrap_err`=0.
- IDLE + `start`=1:
  - latch all eight `cfg_lim_*`
  - clear all counters
  - clear `wrap_err`
  - `busy`←1
- RUN + `start`: ignored. Limits and counters are unaffected.
- RUN + `done`=1: `busy`←0. Counters and limits hold their values.
- Counter step rule, each counter c with limit L:
  - if c==L: c←0 and emit carry
  - otherwise: c←c+1, no carry
  - Arithmetic is unsigned CW-bit.
- Step sources:
  - `cnt_npu` steps on `ctrl_en_npu`.
  - `cnt_hmode` steps on `ctrl_en_hmode`.
  - `cnt_vmode` steps on `ctrl_en_vmode`.
  - `cnt_ifmaps` steps on the `cnt_npu` carry.
  - `cnt_res` steps on `ctrl_wr_mem`.
  - `cnt_tileh` steps on the `cnt_res` carry.
  - `cnt_tilev` steps on the `cnt_tileh` carry.
  - `cnt_ofmaps` steps on the `cnt_tilev` carry.
  - A carry out of `cnt_ofmaps` sets `wrap_err`.
- Counters update only in RUN. Strobes received in IDLE are ignored.
- Chains are independent: same-cycle `ctrl_en_npu` and `ctrl_wr_mem` both take effect.
- A carry ripples through the whole chain in the same cycle. Example: `cnt_res`, `cnt_tileh` and `cnt_tilev` all at limit when `ctrl_wr_mem` fires → all three go to 0 and `cnt_ofmaps` increments, all at one edge.
- `s_tc_x` = `busy` & (cnt_x==L_x). The flags are combinational from registers only and never depend on the strobe inputs.
- A limit of 0 means the flag is 1 for the whole of RUN, and every strobe produces a carry.
- `done` and a strobe in the same cycle: the strobe is applied, then `busy`←0.

## Timing
- Start latency: `start` sampled at edge N → `busy`=1 and counters=0 visible after edge N. `s_tc_*` is valid in the cycle after N.
- Step latency: a strobe at edge N changes the counter and its flag after edge N. There is no combinational path from any strobe to `s_tc_*` or `idx_*`.
- Reset dominates every other input in the same cycle, including `start` and `done`.
- Reset in the middle of RUN aborts immediately. All state returns to reset values at that edge.

## Configuration
- `NPU_LOOP_PERF_EN` defined:
  - adds output `perf_cycles` (32 bits)
  - it counts cycles with `busy`=1, cleared on accepted `start`, saturating at 0xFFFFFFFF
  - it holds its value in IDLE and resets to 0
- `NPU_LOOP_PERF_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset and idle strobes: reset, then pulse every strobe with `busy`=0 → all `idx_*`=0, all `s_tc_*`=0, `busy`=0.
- Basic wrap: `cfg_lim_npu`=2, `cfg_lim_ifmaps`=1, start, then 6 `ctrl_en_npu` pulses.
  - `idx_npu` sequence: 1,2,0,1,2,0
  - `s_tc_npu_ptr` high after pulses 2 and 5
  - `idx_ifmaps` sequence: 0,0,1,1,1,0
- Full ripple: all res-chain limits=1, start, 16 `ctrl_wr_mem` pulses.
  - after pulse 15: `s_tc_res`, `s_tc_tileh`, `s_tc_tilev` and `s_tc_ofmaps` all =1
  - pulse 16: all four counters → 0 and `wrap_err`=1
- Simultaneous events: `ctrl_en_npu`, `ctrl_wr_mem` and `done` in one cycle → both counters step and `busy`=0 on the next cycle. A later `start` clears `wrap_err` and the counters.
- Start while busy and zero limits: `cfg_lim_vmode`=0, start, then change cfg and pulse `start` again.
  - limits unchanged
  - `s_tc_vmode`=1 throughout RUN, `idx` unchanged on the second start
- Reset mid-run: assert `rst_n`=0 with counters non-zero → all outputs 0 next cycle. With `NPU_LOOP_PERF_EN`, `perf_cycles`=0 and it then counts the exact number of RUN cycles.
